// File: rtl/pcs_counter_pkg.sv
// ============================================================================
// Module : pcs_counter_pkg
// Brief  : Shared mode/state encodings for the multi-channel PCS timing counter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package pcs_counter_pkg;

    localparam int C_MODE_W = 2;

    typedef enum logic [1:0] {
        MODE_WRAP     = 2'd0,
        MODE_ONESHOT  = 2'd1,
        MODE_SATURATE = 2'd2
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } cnt_state_e;

    // The reserved encoding 2'b11 behaves as WRAP.
    function automatic mode_e decode_mode(input logic [C_MODE_W-1:0] raw);
        case (raw)
            2'd1:    return MODE_ONESHOT;
            2'd2:    return MODE_SATURATE;
            default: return MODE_WRAP;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/multi_channel_counter_if.sv
// ============================================================================
// Module : multi_channel_counter_if
// Brief  : Control/status bundle for the multi-channel counter block.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface multi_channel_counter_if #(
    parameter int N_CHANNELS = 4,
    parameter int NB_COUNT   = 8
);
    logic                           valid;
    logic [N_CHANNELS-1:0]          enable;
    logic [N_CHANNELS-1:0]          clear;
    logic [2*N_CHANNELS-1:0]        mode;
    logic [NB_COUNT*N_CHANNELS-1:0] period;
    logic [NB_COUNT*N_CHANNELS-1:0] counter;
    logic [N_CHANNELS-1:0]          tc;
    logic [N_CHANNELS-1:0]          busy;
    logic [N_CHANNELS-1:0]          done;
    logic                           tc_any;

    modport master (
        output valid, enable, clear, mode, period,
        input  counter, tc, busy, done, tc_any
    );

    modport slave (
        input  valid, enable, clear, mode, period,
        output counter, tc, busy, done, tc_any
    );
endinterface

`default_nettype wire

// File: rtl/counter_channel.sv
// ============================================================================
// Module : counter_channel
// Brief  : One valid-gated counter channel: IDLE/RUN/HOLD FSM, counter, config latch.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module counter_channel
    import pcs_counter_pkg::*;
#(
    parameter int MAX_COUNT = 255,
    parameter int NB_COUNT  = $clog2(MAX_COUNT + 1)
) (
    input  wire logic                i_clk,
    input  wire logic                i_rst_n,
    input  wire logic                i_valid,
    input  wire logic                i_enable,
    input  wire logic                i_clear,
    input  wire logic [1:0]          i_mode,
    input  wire logic [NB_COUNT-1:0] i_period,
    output logic      [NB_COUNT-1:0] o_counter,
    output logic                     o_tc,
    output logic                     o_busy,
    output logic                     o_done
);

    cnt_state_e          r_state;
    logic [NB_COUNT-1:0] r_counter;
    logic [NB_COUNT-1:0] r_period;
    mode_e               r_mode;
    logic                r_tc;

    cnt_state_e          w_state_nxt;
    logic [NB_COUNT-1:0] w_counter_nxt;
    logic [NB_COUNT-1:0] w_period_nxt;
    mode_e               w_mode_nxt;
    logic                w_tc_nxt;
    logic [NB_COUNT-1:0] w_eff_period;
    logic [NB_COUNT-1:0] w_step_period;
    mode_e               w_step_mode;
    logic [NB_COUNT-1:0] w_cnt_inc;
    logic                w_step;

    // The upper clamp only exists when the period port can express values above MAX_COUNT.
    if (MAX_COUNT < (2 ** NB_COUNT) - 1) begin : g_clamp
        always_comb begin
            if (i_period == '0)
                w_eff_period = NB_COUNT'(1);
            else if (i_period > NB_COUNT'(MAX_COUNT))
                w_eff_period = NB_COUNT'(MAX_COUNT);
            else
                w_eff_period = i_period;
        end
    end else begin : g_noclamp
        assign w_eff_period = (i_period == '0) ? NB_COUNT'(1) : i_period;
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_counter_nxt = r_counter;
        w_period_nxt  = r_period;
        w_mode_nxt    = r_mode;
        w_tc_nxt      = 1'b0;
        w_step        = 1'b0;
        w_step_period = r_period;
        w_step_mode   = r_mode;
        w_cnt_inc     = r_counter + NB_COUNT'(1);

        if (i_clear) begin
            w_state_nxt   = ST_IDLE;
            w_counter_nxt = '0;
        end else if (i_valid) begin
            case (r_state)
                ST_IDLE: begin
                    if (i_enable) begin
                        // Start behaves as a step from 0 so a period of 1 terminates immediately.
                        w_period_nxt  = w_eff_period;
                        w_mode_nxt    = decode_mode(i_mode);
                        w_step_period = w_eff_period;
                        w_step_mode   = decode_mode(i_mode);
                        w_cnt_inc     = NB_COUNT'(1);
                        w_step        = 1'b1;
                    end
                end
                ST_RUN: w_step = 1'b1;
                ST_HOLD: begin
                    if (!i_enable) begin
                        w_state_nxt   = ST_IDLE;
                        w_counter_nxt = '0;
                    end
                end
                default: begin
                    w_state_nxt   = ST_IDLE;
                    w_counter_nxt = '0;
                end
            endcase

            if (w_step) begin
                if (w_cnt_inc == w_step_period) begin
                    w_tc_nxt = 1'b1;
                    case (w_step_mode)
                        MODE_SATURATE: begin
                            w_counter_nxt = w_step_period;
                            w_state_nxt   = ST_HOLD;
                        end
                        MODE_ONESHOT: begin
                            w_counter_nxt = '0;
                            w_state_nxt   = ST_HOLD;
                        end
                        default: begin
                            w_counter_nxt = '0;
                            w_state_nxt   = i_enable ? ST_RUN : ST_IDLE;
                        end
                    endcase
                end else begin
                    w_counter_nxt = w_cnt_inc;
                    w_state_nxt   = ST_RUN;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_IDLE;
            r_counter <= '0;
            r_period  <= '0;
            r_mode    <= MODE_WRAP;
            r_tc      <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_counter <= w_counter_nxt;
            r_period  <= w_period_nxt;
            r_mode    <= w_mode_nxt;
            r_tc      <= w_tc_nxt;
        end
    end

    assign o_counter = r_counter;
    assign o_tc      = r_tc;
    assign o_busy    = (r_state == ST_RUN);
    assign o_done    = (r_state == ST_HOLD);

endmodule

`default_nettype wire

// File: rtl/multi_channel_counter.sv
// ============================================================================
// Module : multi_channel_counter
// Brief  : N independent valid-gated terminal-count timers for PCS lane timing.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module multi_channel_counter
    import pcs_counter_pkg::*;
#(
    parameter int N_CHANNELS = 4,
    parameter int MAX_COUNT  = 255,
    parameter int NB_COUNT   = $clog2(MAX_COUNT + 1)
) (
    input wire logic                i_clk,
    input wire logic                i_rst_n,
    multi_channel_counter_if.slave  bus
);

    logic [NB_COUNT*N_CHANNELS-1:0] w_counter;
    logic [N_CHANNELS-1:0]          w_tc;
    logic [N_CHANNELS-1:0]          w_busy;
    logic [N_CHANNELS-1:0]          w_done;

    for (genvar g = 0; g < N_CHANNELS; g++) begin : g_ch
        counter_channel #(
            .MAX_COUNT (MAX_COUNT),
            .NB_COUNT  (NB_COUNT)
        ) u_channel (
            .i_clk     (i_clk),
            .i_rst_n   (i_rst_n),
            .i_valid   (bus.valid),
            .i_enable  (bus.enable[g]),
            .i_clear   (bus.clear[g]),
            .i_mode    (bus.mode[C_MODE_W*g +: C_MODE_W]),
            .i_period  (bus.period[NB_COUNT*g +: NB_COUNT]),
            .o_counter (w_counter[NB_COUNT*g +: NB_COUNT]),
            .o_tc      (w_tc[g]),
            .o_busy    (w_busy[g]),
            .o_done    (w_done[g])
        );
    end

    assign bus.counter = w_counter;
    assign bus.tc      = w_tc;
    assign bus.busy    = w_busy;
    assign bus.done    = w_done;
    assign bus.tc_any  = |w_tc;

endmodule

`default_nettype wire

// File: tb/tb_multi_channel_counter.sv
// ============================================================================
// Module : tb_multi_channel_counter
// Brief  : Directed self-checking bench for multi_channel_counter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_multi_channel_counter;

    localparam int N_CH = 4;
    localparam int MAXC = 255;
    localparam int NB   = 8;

    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;
    int   n_tc;

    multi_channel_counter_if #(.N_CHANNELS(N_CH), .NB_COUNT(NB)) bus ();

    multi_channel_counter #(
        .N_CHANNELS (N_CH),
        .MAX_COUNT  (MAXC),
        .NB_COUNT   (NB)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int ch, input logic [1:0] m, input logic [7:0] p);
        bus.mode[2*ch +: 2]   = m;
        bus.period[NB*ch +: NB] = p;
    endtask

    function automatic logic [7:0] cnt(input int ch);
        return bus.counter[NB*ch +: NB];
    endfunction

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst_n      = 1'b0;
        bus.valid  = 1'b0;
        bus.enable = '0;
        bus.clear  = '0;
        bus.mode   = '0;
        bus.period = '0;
        tick();
        tick();
        chk("rst_counter", 32'(bus.counter), 32'h0);
        chk("rst_tc",      32'(bus.tc),      32'h0);
        chk("rst_busy",    32'(bus.busy),    32'h0);
        chk("rst_done",    32'(bus.done),    32'h0);
        chk("rst_tc_any",  32'(bus.tc_any),  32'h0);
        rst_n = 1'b1;

        // WRAP ch0, period 4, enable and valid held high
        set_ch(0, 2'd0, 8'd4);
        bus.enable = 4'b0001;
        bus.valid  = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk($sformatf("wrap_cnt_%0d", i), 32'(cnt(0)), 32'(i % 4));
            chk($sformatf("wrap_tc_%0d", i), 32'(bus.tc[0]), 32'((i % 4) == 0));
        end
        chk("wrap_busy", 32'(bus.busy), 32'h1);
        chk("wrap_other_idle", 32'(bus.counter[31:8]), 32'h0);

        // Period change mid-run only takes effect on the next start
        set_ch(0, 2'd0, 8'd8);
        for (int i = 1; i <= 4; i++) tick();
        chk("chg_still4_tc", 32'(bus.tc[0]), 32'h1);
        chk("chg_still4_cnt", 32'(cnt(0)), 32'h0);
        bus.enable = 4'b0000;
        for (int i = 1; i <= 4; i++) tick();
        chk("chg_stop_tc", 32'(bus.tc[0]), 32'h1);
        chk("chg_stop_busy", 32'(bus.busy[0]), 32'h0);
        bus.enable = 4'b0001;
        for (int i = 1; i <= 4; i++) tick();
        chk("chg_p8_cnt4", 32'(cnt(0)), 32'h4);
        chk("chg_p8_tc4", 32'(bus.tc[0]), 32'h0);
        for (int i = 5; i <= 8; i++) tick();
        chk("chg_p8_tc8", 32'(bus.tc[0]), 32'h1);
        chk("chg_p8_cnt8", 32'(cnt(0)), 32'h0);
        bus.enable = 4'b0000;
        for (int i = 1; i <= 8; i++) tick();
        chk("chg_p8_idle", 32'(bus.busy[0]), 32'h0);

        // ONESHOT ch1, period 3, valid 1,0,1,1
        set_ch(1, 2'd1, 8'd3);
        bus.enable = 4'b0010;
        tick();
        chk("os_cnt1", 32'(cnt(1)), 32'h1);
        chk("os_busy", 32'(bus.busy), 32'h2);
        bus.enable = 4'b0000;
        bus.valid  = 1'b0;
        tick();
        chk("os_frozen", 32'(cnt(1)), 32'h1);
        chk("os_frozen_tc", 32'(bus.tc), 32'h0);
        bus.valid = 1'b1;
        tick();
        chk("os_cnt2", 32'(cnt(1)), 32'h2);
        tick();
        chk("os_term_cnt", 32'(cnt(1)), 32'h0);
        chk("os_term_tc", 32'(bus.tc), 32'h2);
        chk("os_term_any", 32'(bus.tc_any), 32'h1);
        chk("os_done", 32'(bus.done), 32'h2);
        chk("os_not_busy", 32'(bus.busy), 32'h0);
        bus.valid = 1'b0;
        tick();
        chk("os_hold_novalid", 32'(bus.done), 32'h2);
        chk("os_hold_notc", 32'(bus.tc_any), 32'h0);
        bus.valid = 1'b1;
        tick();
        chk("os_exit_done", 32'(bus.done), 32'h0);
        chk("os_exit_busy", 32'(bus.busy), 32'h0);

        // SATURATE ch2 at the largest legal period
        set_ch(2, 2'd2, 8'd255);
        bus.enable = 4'b0100;
        n_tc = 0;
        for (int k = 1; k <= 255; k++) begin
            tick();
            if (bus.tc[2]) n_tc++;
            if (k == 254) chk("sat_cnt254", 32'(cnt(2)), 32'd254);
        end
        chk("sat_cnt255", 32'(cnt(2)), 32'd255);
        chk("sat_tc_last", 32'(bus.tc[2]), 32'h1);
        chk("sat_tc_once", 32'(n_tc), 32'h1);
        chk("sat_done", 32'(bus.done), 32'h4);
        tick();
        chk("sat_hold_cnt", 32'(cnt(2)), 32'd255);
        chk("sat_hold_tc", 32'(bus.tc_any), 32'h0);
        bus.enable = 4'b0000;
        tick();
        chk("sat_exit_cnt", 32'(cnt(2)), 32'h0);
        chk("sat_exit_done", 32'(bus.done), 32'h0);
        set_ch(2, 2'd2, 8'd0);
        bus.enable = 4'b0100;
        tick();
        chk("sat_p0_tc", 32'(bus.tc), 32'h4);
        chk("sat_p0_cnt", 32'(cnt(2)), 32'h1);
        chk("sat_p0_done", 32'(bus.done), 32'h4);
        bus.enable = 4'b0000;
        tick();

        // Clear coinciding with the terminal cycle on ch3
        set_ch(3, 2'd0, 8'd2);
        bus.enable = 4'b1000;
        tick();
        chk("clr_cnt1", 32'(cnt(3)), 32'h1);
        bus.clear = 4'b1000;
        tick();
        chk("clr_cnt", 32'(cnt(3)), 32'h0);
        chk("clr_tc", 32'(bus.tc), 32'h0);
        chk("clr_busy", 32'(bus.busy), 32'h0);
        bus.clear  = 4'b0000;
        bus.enable = 4'b0000;
        tick();
        chk("clr_stays_idle", 32'(bus.busy), 32'h0);

        // Simultaneous terminals on ch0 and ch3
        set_ch(0, 2'd0, 8'd2);
        bus.enable = 4'b1001;
        tick();
        tick();
        chk("sim_tc", 32'(bus.tc), 32'h9);
        chk("sim_any", 32'(bus.tc_any), 32'h1);
        bus.enable = 4'b0000;
        tick();
        tick();
        chk("sim_idle", 32'(bus.busy), 32'h0);

        // Async reset mid-count, reserved mode on ch1
        set_ch(0, 2'd0, 8'd10);
        set_ch(1, 2'd3, 8'd10);
        set_ch(2, 2'd0, 8'd10);
        set_ch(3, 2'd0, 8'd10);
        bus.enable = 4'b1111;
        for (int i = 0; i < 3; i++) tick();
        chk("ar_pre_cnt", 32'(bus.counter), 32'h03030303);
        chk("ar_pre_busy", 32'(bus.busy), 32'hF);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_cnt", 32'(bus.counter), 32'h0);
        chk("ar_busy", 32'(bus.busy), 32'h0);
        chk("ar_done_tc", 32'({bus.done, bus.tc, bus.tc_any}), 32'h0);
        #2 rst_n = 1'b1;
        for (int ch = 0; ch < N_CH; ch++) bus.period[NB*ch +: NB] = 8'd3;
        tick();
        tick();
        chk("ar_restart_cnt", 32'(bus.counter), 32'h02020202);
        tick();
        chk("ar_restart_tc", 32'(bus.tc), 32'hF);
        chk("ar_restart_cnt0", 32'(bus.counter), 32'h0);
        chk("ar_rsvd_wrap", 32'({bus.busy, bus.done}), 32'hF0);
        bus.enable = 4'b0000;
        for (int i = 0; i < 3; i++) tick();
        chk("ar_final_idle", 32'({bus.busy, bus.done}), 32'h00);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
